bin_cnt_param: RTL

Parametrised modulo-N up/down binary counter with an integrated clock-enable prescaler. It replaces the fixed 4-bit free-running counter with derived clock. Everything runs on the single system clock; the prescaler produces an internal count tick instead of a divided clock. Adds synchronous load, synchronous clear, direction control, terminal-count and wrap flags. Used wherever the lab designs need a slow, loadable or bidirectional count.

---
 rtl/bin_cnt_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/bin_cnt_param.sv
// Modulo-N up/down binary counter with a clock-enable prescaler, load, clear and wrap flag.
// Optional Gray-coded output enabled by defining BIN_CNT_PARAM_GRAY_OUT_EN.
module bin_cnt_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned DIV_RATIO = 1,
  parameter int unsigned PRE_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap
`ifdef BIN_CNT_PARAM_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] counter_gray
`endif
);

  // Elaboration-time sanity checks on the parameter set.
  if (WIDTH < 1) begin : gen_bad_width
    $error("bin_cnt_param: WIDTH must be at least 1");
  end
  if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : gen_bad_modulus
    $error("bin_cnt_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (DIV_RATIO < 1 || 64'(DIV_RATIO) > (64'(1) << PRE_W)) begin : gen_bad_div
    $error("bin_cnt_param: DIV_RATIO must satisfy 1 <= DIV_RATIO <= 2**PRE_W");
  end

  localparam logic [WIDTH-1:0] CntMax = WIDTH'(MODULUS - 1);
  localparam logic [PRE_W-1:0] PreMax = PRE_W'(DIV_RATIO - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] load_clamped;

  assign at_max       = (cnt_q == CntMax);
  assign at_zero      = (cnt_q == '0);
  assign load_clamped = (load_val > CntMax) ? CntMax : load_val;

  // With DIV_RATIO=1, PreMax is 0 so pre never leaves 0 and tick degenerates to en.
  assign tick = en & (pre_q == PreMax);

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (load) begin
      pre_d = '0;
      cnt_d = load_clamped;
    end else begin
      if (en) begin
        pre_d = (pre_q == PreMax) ? '0 : pre_q + PRE_W'(1);
      end
      if (tick) begin
        if (up_dn) begin
          cnt_d  = at_max ? '0 : cnt_q + WIDTH'(1);
          wrap_d = at_max;
        end else begin
          cnt_d  = at_zero ? CntMax : cnt_q - WIDTH'(1);
          wrap_d = at_zero;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (cnt_q <= CntMax) else $error("bin_cnt_param: counter out of range");
      assert (pre_q <= PreMax) else $error("bin_cnt_param: prescaler out of range");
    end
  end

  assign counter = cnt_q;
  assign wrap    = wrap_q;
  // Terminal count follows direction combinationally so a direction flip re-evaluates at once.
  assign tc      = up_dn ? at_max : at_zero;

`ifdef BIN_CNT_PARAM_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= cnt_d ^ (cnt_d >> 1);
    end
  end

  assign counter_gray = gray_q;
`endif

endmodule
